// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per enabled clock out.
// Optional trailing even-parity bit per word when SERIALIZER_PARITY_EN is defined.
module bit_stream_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             enable,
   output logic             x_out,
   output logic             x_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   function automatic logic [WIDTH-1:0] order_word(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = MSB_FIRST ? w[i] : w[WIDTH-1-i];
      end
      return r;
   endfunction

`ifdef SERIALIZER_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction

   logic par_r;
`endif

   state_t           state_r;
   // x_out_r is the head of the shift register; shreg_r holds the bits still to come
   logic             x_out_r;
   logic [WIDTH-2:0] shreg_r;
   logic [CW-1:0]    bit_cnt_r;
   logic [CW-1:0]    next_cnt_s;
   logic             last_r;
   logic             busy_r;
   logic [WIDTH-1:0] load_word_s;
   logic             accept_s;

   assign load_word_s = order_word(in_data);
   assign next_cnt_s  = bit_cnt_r + CW'(1);
   // last_r is only ever set on the final stream bit, so this covers both the idle and reload cases
   assign in_ready    = !rst && ((state_r == IDLE) || (last_r && enable));
   assign accept_s    = in_valid && in_ready;

   assign x_out    = x_out_r;
   assign x_valid  = busy_r && enable;
   assign last_bit = last_r;
   assign busy     = busy_r;

   // Serializer FSM with registered stream outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         x_out_r   <= 1'b0;
         shreg_r   <= {(WIDTH-1){1'b0}};
         bit_cnt_r <= {CW{1'b0}};
         last_r    <= 1'b0;
         busy_r    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_r     <= 1'b0;
`endif
      end else if (accept_s) begin
         state_r   <= SHIFT;
         x_out_r   <= load_word_s[WIDTH-1];
         shreg_r   <= load_word_s[WIDTH-2:0];
         bit_cnt_r <= {CW{1'b0}};
         last_r    <= 1'b0;
         busy_r    <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
         par_r     <= even_parity(in_data);
`endif
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= IDLE;
            end
            SHIFT: begin
               if (enable) begin
                  if (bit_cnt_r == LAST_CNT) begin
`ifdef SERIALIZER_PARITY_EN
                     state_r <= PARITY;
                     x_out_r <= par_r;
                     last_r  <= 1'b1;
`else
                     state_r <= IDLE;
                     x_out_r <= 1'b0;
                     last_r  <= 1'b0;
                     busy_r  <= 1'b0;
`endif
                  end else begin
                     x_out_r   <= shreg_r[WIDTH-2];
                     shreg_r   <= shreg_r << 1;
                     bit_cnt_r <= next_cnt_s;
`ifdef SERIALIZER_PARITY_EN
                     last_r    <= 1'b0;
`else
                     last_r    <= (next_cnt_s == LAST_CNT);
`endif
                  end
               end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
               if (enable) begin
                  state_r <= IDLE;
                  x_out_r <= 1'b0;
                  last_r  <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
`endif
            default: begin
               state_r <= IDLE;
               x_out_r <= 1'b0;
               last_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench for bit_stream_serializer: directed vector table, corner sequences,
// and randomized traffic against a bit-queue reference model.
module tb_bit_stream_serializer;

   localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int BITS = W + (PAR ? 1 : 0);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_data = 8'h00;
   logic         in_valid = 1'b0;
   logic         enable = 1'b0;
   logic         in_ready, x_out, x_valid, last_bit, busy;

   logic [W-1:0] l_data = 8'h00;
   logic         l_valid = 1'b0;
   logic         l_en = 1'b1;
   logic         l_ready, l_x_out, l_x_valid, l_last_bit, l_busy;

   int errors = 0;
   int checks = 0;

   bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .enable(enable), .x_out(x_out), .x_valid(x_valid), .last_bit(last_bit), .busy(busy)
   );

   bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
      .enable(l_en), .x_out(l_x_out), .x_valid(l_x_valid), .last_bit(l_last_bit), .busy(l_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the pending stream as a queue of {bit, is_final_bit_of_word}
   typedef struct packed {logic b; logic l;} sbit_t;
   sbit_t q[$];
   logic s_xo, s_xv, s_lb, s_acc, s_rdy;

   function automatic void push_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) q.push_back(sbit_t'{w[i], (i == 0) && !PAR});
      if (PAR) q.push_back(sbit_t'{^w, 1'b1});
   endfunction

   task automatic step();
      logic eb, er;
      @(negedge clk);
      eb = (q.size() != 0);
      er = eb ? (q[0].l && enable) : 1'b1;
      s_xo = x_out; s_xv = x_valid; s_lb = last_bit; s_rdy = in_ready;
      chk("busy", busy, eb);
      chk("x_valid", x_valid, eb && enable);
      chk("in_ready", in_ready, er);
      chk("x_out", x_out, eb ? q[0].b : 1'b0);
      chk("last_bit", last_bit, eb ? q[0].l : 1'b0);
      s_acc = in_valid && er;
      if (eb && enable) void'(q.pop_front());
      if (s_acc) push_word(in_data);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic iv; logic [W-1:0] d; logic en;
      logic xo; logic xv; logic lb; logic by; logic rdy;
   } vec_t;
   vec_t tbl[11];
   logic lsb_seq[8];

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, rcnt;

      // Single 8'hD8 word, MSB first: accept cycle k, bits k+1..k+8, idle after
      tbl[0] = '{1'b1, 8'hD8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef SERIALIZER_PARITY_EN
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
      tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      lsb_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset state
      enable = 1'b1;
      #12;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_x_valid", x_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_x_out", x_out, 1'b0);
      chk("rst_last_bit", last_bit, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("ready_after_reset", in_ready, 1'b1);

      // Directed vector table
      for (int i = 0; i < 11; i++) begin
         in_valid = tbl[i].iv; in_data = tbl[i].d; enable = tbl[i].en;
         @(negedge clk);
         chk($sformatf("tbl%0d_x_out", i), x_out, tbl[i].xo);
         chk($sformatf("tbl%0d_x_valid", i), x_valid, tbl[i].xv);
         chk($sformatf("tbl%0d_last_bit", i), last_bit, tbl[i].lb);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].by);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;

      // Back-to-back D8 then 6C with in_valid held
      enable = 1'b1; in_valid = 1'b1; in_data = 8'hD8;
      step();
      chk("b2b_accept1", s_acc, 1'b1);
      in_data = 8'h6C;
      cnt = 0; rcnt = 0;
      for (int i = 0; i < 2 * BITS; i++) begin
         step();
         if (s_xv) cnt++;
         if (i < BITS && s_rdy) rcnt++;
         if (s_acc) in_valid = 1'b0;
      end
      chk("b2b_contiguous_valid", cnt, 2 * BITS);
      chk("b2b_ready_once", rcnt, 1);
      step();

      // Stall after 4th bit of D8
      in_valid = 1'b1; in_data = 8'hD8;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_x_out", s_xo, 1'b1);
         chk("stall_x_valid", s_xv, 1'b0);
      end
      enable = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      chk("stall_drained", q.size(), 0);
      step();

      // LSB-first instance
      l_valid = 1'b1; l_data = 8'hD8;
      @(negedge clk);
      chk("lsb_ready", l_ready, 1'b1);
      @(posedge clk); #1;
      l_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("lsb_bit%0d", i), l_x_out, lsb_seq[i]);
         chk("lsb_x_valid", l_x_valid, 1'b1);
         chk("lsb_busy", l_busy, 1'b1);
         chk("lsb_last_bit", l_last_bit, (i == 7) && !PAR);
         @(posedge clk); #1;
      end
      repeat (3) step();

      // Reset mid-word after the 3rd bit
      in_valid = 1'b1; in_data = 8'hD8;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("midrst_x_valid", x_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b1; in_data = 8'h6C;
      step();
      chk("midrst_accept", s_acc, 1'b1);
      in_valid = 1'b0;
      step();
      chk("midrst_first_bit", s_xo, 1'b0);
      repeat (BITS) step();

`ifdef SERIALIZER_PARITY_EN
      // Parity bit for 8'h01
      in_valid = 1'b1; in_data = 8'h01;
      step();
      in_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < BITS; i++) begin
         step();
         if (s_lb) cnt++;
      end
      chk("par01_bit", s_xo, 1'b1);
      chk("par01_last_once", cnt, 1);
      step();
`endif

      // Randomized traffic against the reference model
      in_valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!(in_valid && !s_acc)) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = W'($urandom);
         end
         enable = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0; enable = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      chk("rand_drained", q.size(), 0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-to-serial front end that feeds the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on x_out.
- Supports zero-bubble back-to-back words, so the detector sees a continuous stream and can match patterns that straddle word boundaries.
- x_valid qualifies each bit; downstream uses it as its clock enable.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- enable  input  1  downstream advance; 0 stalls the stream.
- x_out  output  1  current serial bit.
- x_valid  output  1  x_out is presented and consumed this cycle.
- last_bit  output  1  x_out is the final bit of the current word.
- busy  output  1  a word is in flight.

Behaviour:
- Reset:
  - state=IDLE; shift register=0; bit_cnt=0.
  - x_out=0, x_valid=0, last_bit=0, busy=0.
  - in_ready=0 while rst is asserted, and 1 from the first cycle after deassertion.
- States:
  - IDLE, SHIFT.
  - PARITY is added only under the optional feature.
- in_ready:
  - Combinational.
  - 1 in IDLE.
  - 1 in SHIFT when last_bit=1 and enable=1 (zero-bubble reload).
  - 0 otherwise.
- Accept:
  - Occurs when in_valid && in_ready at a rising edge.
  - Loads the shift register (bit-reversed when MSB_FIRST=0) and sets bit_cnt=0 and state=SHIFT.
- Latency: a word accepted at edge k presents its first bit on x_out during cycle k+1.
- In SHIFT:
  - x_out = head bit of the shift register; busy=1.
  - x_valid = enable.
  - last_bit = (bit_cnt==WIDTH-1).
- Advance:
  - On each edge with enable=1 in SHIFT, shift by one and increment bit_cnt.
  - At bit_cnt==WIDTH-1, go to IDLE unless a new word is accepted on the same edge; in that case reload and stay in SHIFT with no gap.
- Stall: with enable=0, the shift register, bit_cnt, x_out and state all hold, and x_valid=0.
- IDLE: x_out=0, x_valid=0, last_bit=0, busy=0.
- Counter: bit_cnt is clog2(WIDTH) bits wide. It never exceeds WIDTH-1 and is cleared on every load.
- in_valid with in_ready=0: the word is not taken. The upstream must hold in_data and in_valid stable until accepted.
- Reset mid-word: the partial word is discarded and no further bits are emitted. The block restarts in IDLE.
- No combinational path from in_data to x_out.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit, the block enters PARITY for one enabled cycle.
  - In PARITY, x_out = even parity (XOR) of the word; x_valid = enable; last_bit=1.
  - On the last data bit, last_bit=0 and in_ready=0.
  - The zero-bubble in_ready condition moves to the PARITY cycle.
  - Each word occupies WIDTH+1 stream bits.
- Undefined: the PARITY state and its logic are absent; each word occupies exactly WIDTH bits.

Test Plan:
- Single word, MSB_FIRST=1:
  - Stimulus: in_data=8'hD8, enable=1.
  - Required: x_out=1,1,0,1,1,0,0,0 on cycles k+1..k+8; x_valid high for exactly 8 cycles; last_bit high on cycle k+8 only; busy back to 0 on k+9.
- Back-to-back:
  - Stimulus: 8'hD8 then 8'h6C with in_valid held.
  - Required: 16 contiguous x_valid cycles with no gap; in_ready high only on cycle k+8 during the first word.
- Stall:
  - Stimulus: enable=0 for 3 cycles after the 4th bit of 8'hD8.
  - Required: x_out holds 1, x_valid=0 for those 3 cycles, and the remaining bits 1,0,0,0 then follow in order.
- Reset mid-word:
  - Stimulus: assert rst after the 3rd bit.
  - Required: x_valid=0 and in_ready=0 immediately; the next word after release serializes from its first bit.
- LSB-first:
  - Stimulus: MSB_FIRST=0, in_data=8'hD8.
  - Required: x_out=0,0,0,1,1,0,1,1.
- Parity (SERIALIZER_PARITY_EN):
  - Stimulus: 8'hD8, then 8'h01.
  - Required: 9th bit is 0 for 8'hD8 and 1 for 8'h01; last_bit asserts only on the parity bit.
